// File: rtl/life_dpgen.sv
// life_dpgen -- Conway's Game of Life datapath for a 16x16 grid held in a
// single 256-bit register. The grid is seeded from a parallel pattern and
// advances one generation per clock while enabled.
//
// Cell mapping: row r occupies bits [16r+15:16r]; column c is bit 16r+c.
// Bit value 1 = live. Cells outside the grid count as dead (no wrap).
//
// Ports:
//   clk    in   1    system clock, rising edge
//   reset  in   1    synchronous active-high; loads gin into the grid
//   gin    in   256  seed pattern
//   clear  in   1    synchronous active-high; zeroes the grid
//   start  in   1    run enable; advance one generation per clock
//   gout   out  256  current grid (straight from the state register)
module life_dpgen (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] gin,
  input  logic         clear,
  input  logic         start,
  output logic [255:0] gout
);

  logic [255:0] r_grid;
  logic [255:0] w_next;

  // Out-of-range coordinates read as dead, which gives the no-wrap boundary.
  function automatic logic cell_at(input logic [255:0] g, input int r, input int c);
    logic v;
    if (r < 0 || r > 15 || c < 0 || c > 15) begin
      v = 1'b0;
    end else begin
      v = g[8'(r * 16 + c)];
    end
    return v;
  endfunction

  function automatic logic next_cell(input logic [255:0] g, input int r, input int c);
    logic [3:0] n;
    logic       alive;
    n = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          n = n + {3'b000, cell_at(g, r + dr, c + dc)};
        end
      end
    end
    if (cell_at(g, r, c)) begin
      alive = (n == 4'd2) || (n == 4'd3);
    end else begin
      alive = (n == 4'd3);
    end
    return alive;
  endfunction

  // All 256 cells evaluated in parallel from the current state.
  always_comb begin
    w_next = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        w_next[8'(r * 16 + c)] = next_cell(r_grid, r, c);
      end
    end
  end

  // Priority: reset (seed load) > clear > start (advance) > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grid <= gin;
    end else if (clear) begin
      r_grid <= '0;
    end else if (start) begin
      r_grid <= w_next;
    end
  end

  assign gout = r_grid;

endmodule

// File: tb/tb_life_dpgen.sv
module tb_life_dpgen;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [255:0] gin = '0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic [255:0] gout;

  life_dpgen dut (
    .clk  (clk),
    .reset(reset),
    .gin  (gin),
    .clear(clear),
    .start(start),
    .gout (gout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [255:0] sb_exp[$];
  string        sb_name[$];

  // Independent reference: unpack into a dead-padded 18x18 array and count.
  function automatic logic [255:0] ref_gen(input logic [255:0] g);
    int           pad[0:17][0:17];
    logic [255:0] t;
    logic [255:0] res;
    int           n;
    for (int i = 0; i < 18; i++)
      for (int j = 0; j < 18; j++)
        pad[i][j] = 0;
    t = g;
    for (int i = 0; i < 256; i++) begin
      pad[i / 16 + 1][i % 16 + 1] = t[0] ? 1 : 0;
      t = t >> 1;
    end
    res = '0;
    for (int i = 255; i >= 0; i--) begin
      int r;
      int c;
      r = i / 16 + 1;
      c = i % 16 + 1;
      n = pad[r-1][c-1] + pad[r-1][c] + pad[r-1][c+1]
        + pad[r][c-1]                 + pad[r][c+1]
        + pad[r+1][c-1] + pad[r+1][c] + pad[r+1][c+1];
      res = res << 1;
      if (pad[r][c] == 1) res[0] = (n == 2 || n == 3);
      else                res[0] = (n == 3);
    end
    return res;
  endfunction

  // Drive one cycle of stimulus; optionally queue the grid expected after the edge.
  task automatic cyc(input logic rs, input logic cl, input logic st,
                     input logic [255:0] g, input bit chk,
                     input logic [255:0] exp, input string name);
    @(negedge clk);
    reset = rs;
    clear = cl;
    start = st;
    gin   = g;
    if (chk) begin
      sb_exp.push_back(exp);
      sb_name.push_back(name);
    end
  endtask

  task automatic show_rows(input logic [255:0] g);
    for (int r = 0; r < 16; r++)
      $display("  row%0d %b", r, g[r*16 +: 16]);
  endtask

  // Monitor: the grid is presented every cycle; compare whenever an expectation is queued.
  initial begin
    logic [255:0] e;
    string        nm;
    forever begin
      @(posedge clk);
      #1;
      if (sb_exp.size() > 0) begin
        e  = sb_exp.pop_front();
        nm = sb_name.pop_front();
        checks++;
        if (gout !== e) begin
          errors++;
          $display("FAIL %s: gout=%h required=%h", nm, gout, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] top;
    logic [255:0] top2;
    logic [255:0] b0;
    logic [255:0] b1;
    logic [255:0] blk;
    logic [255:0] m;
    logic [255:0] seed;

    top  = '0;
    top[255:240] = 16'hFFFF;
    top2 = '0;
    top2[255:240] = 16'h7FFE;
    top2[239:224] = 16'h7FFE;

    blk = '0;
    blk[15:0]  = 16'h0003;
    blk[31:16] = 16'h0003;
    b0 = blk;
    b0[95:80] = 16'h0070;
    b1 = blk;
    b1[79:64]  = 16'h0020;
    b1[95:80]  = 16'h0020;
    b1[111:96] = 16'h0020;

    // Seed load, then top row line.
    cyc(1, 0, 0, top, 1, top, "seed_load0");
    cyc(1, 0, 0, top, 1, top, "seed_load1");
    cyc(0, 0, 1, '0,  1, top2, "top_row_gen1");

    // Blinker plus corner block.
    cyc(1, 0, 0, b0, 1, b0, "blinker_load");
    cyc(0, 0, 1, '0, 1, b1, "blinker_g1");
    cyc(0, 0, 1, '0, 1, b0, "blinker_g2");
    cyc(0, 0, 1, '0, 1, b1, "blinker_g3");
    cyc(0, 0, 1, '0, 1, b0, "blinker_g4");

    // Hold and clear.
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, '0, 1, b0, "hold");
    cyc(0, 1, 0, '0, 1, '0, "clear");
    cyc(0, 0, 1, '0, 1, '0, "zero_stays_zero");
    cyc(1, 0, 0, b0, 1, b0, "reload");
    cyc(0, 1, 1, '0, 1, '0, "clear_over_start");

    // Reset mid-run.
    cyc(1, 0, 0, b0, 1, b0, "midrun_load");
    cyc(0, 0, 1, '0, 1, b1, "midrun_g1");
    cyc(0, 0, 1, '0, 1, b0, "midrun_g2");
    cyc(0, 0, 1, '0, 1, b1, "midrun_g3");
    cyc(1, 1, 1, blk, 1, blk, "midrun_reset");
    cyc(0, 0, 1, '0, 1, blk, "block_still");

    // Random seeds against the reference model.
    for (int s = 0; s < 20; s++) begin
      for (int w = 0; w < 8; w++)
        seed[w*32 +: 32] = $urandom;
      $display("seed %0d:", s);
      show_rows(seed);
      cyc(1, 0, 0, seed, 1, seed, "rand_load");
      m = seed;
      for (int g = 0; g < 10; g++) begin
        m = ref_gen(m);
        cyc(0, 0, 1, '0, 1, m, "rand_gen");
      end
    end

    cyc(0, 0, 0, '0, 0, '0, "");
    for (int i = 0; i < 10 && sb_exp.size() > 0; i++)
      @(negedge clk);
    checks++;
    if (sb_exp.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", sb_exp.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
